agc_sequencer: RTL and testbench

Parametrised instruction sequencer for the AGC core: it owns the program counter (Z), instruction register (B), the extracode and interrupt-inhibit flags, and runtime-writable E/F/super bank registers, which replace the fixed bank parameters of the previous top level. It fetches instruction words through a variable-latency memory handshake and hands decoded fields to the execution datapath. It arbitrates NUM_RUPT prioritised interrupt channels with ZRUPT/BRUPT save and RESUME restore. It sits between the memory block and the control-pulse/ALU datapath.

---
 rtl/agc_sequencer_if.sv | 56 +++++
 rtl/agc_sequencer.sv | 154 +++++++++++++++
 tb/tb_agc_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/agc_sequencer_if.sv
// Sequencer-facing bundle: memory fetch handshake, issue/execute handshake, interrupt lines, debug taps.
// master = sequencer side, slave = memory/datapath side.
interface agc_sequencer_if #(
  parameter int WORD_W   = 16,
  parameter int ADDR_W   = 12,
  parameter int NUM_RUPT = 10
);
  logic                mem_req;
  logic [ADDR_W-1:0]   mem_addr;
  logic [2:0]          mem_ebank;
  logic [4:0]          mem_fbank;
  logic                mem_sbank;
  logic                mem_ack;
  logic [WORD_W-1:0]   mem_rdata;

  logic                ins_valid;
  logic [2:0]          ins_opcode;
  logic [1:0]          ins_qc;
  logic [ADDR_W-1:0]   ins_s;
  logic                ins_extra;

  logic                exec_done;
  logic                exec_branch;
  logic [ADDR_W-1:0]   exec_target;
  logic                exec_extend;
  logic                exec_inhint;
  logic                exec_relint;
  logic                exec_resume;
  logic [2:0]          bank_we;
  logic [4:0]          bank_wdata;

  logic [NUM_RUPT-1:0] rupt_req;
  logic                in_isr;
  logic [ADDR_W-1:0]   z_out;
  logic [ADDR_W-1:0]   zrupt_out;

  modport master (
    output mem_req, mem_addr, mem_ebank, mem_fbank, mem_sbank,
    input  mem_ack, mem_rdata,
    output ins_valid, ins_opcode, ins_qc, ins_s, ins_extra,
    input  exec_done, exec_branch, exec_target, exec_extend, exec_inhint,
    input  exec_relint, exec_resume, bank_we, bank_wdata,
    input  rupt_req,
    output in_isr, z_out, zrupt_out
  );

  modport slave (
    input  mem_req, mem_addr, mem_ebank, mem_fbank, mem_sbank,
    output mem_ack, mem_rdata,
    input  ins_valid, ins_opcode, ins_qc, ins_s, ins_extra,
    output exec_done, exec_branch, exec_target, exec_extend, exec_inhint,
    output exec_relint, exec_resume, bank_we, bank_wdata,
    output rupt_req,
    input  in_isr, z_out, zrupt_out
  );
endinterface

// File: rtl/agc_sequencer.sv
// AGC instruction sequencer: FETCH -> ISSUE -> CHECK loop with banked fetch, extracode and prioritised interrupts.
// Latency: mem_ack -> ins_valid 1 cycle, exec_done -> next mem_req 2 cycles; waits indefinitely on mem_ack / exec_done.
module agc_sequencer #(
  parameter int                WORD_W    = 16,
  parameter int                ADDR_W    = 12,
  parameter int                NUM_RUPT  = 10,
  parameter logic [ADDR_W-1:0] RESET_Z   = 12'o4000,
  parameter logic [ADDR_W-1:0] RUPT_BASE = 12'o4004
) (
  input  logic             clk,
  input  logic             reset,
  agc_sequencer_if.master  bus
);
  typedef enum logic [1:0] {S_FETCH, S_ISSUE, S_CHECK} state_t;

  state_t              state_q, state_d;
  logic                run_q, run_d;
  logic [ADDR_W-1:0]   z_q, z_d, zrupt_q, zrupt_d;
  logic [WORD_W-1:0]   b_q, b_d, brupt_q, brupt_d;
  logic                ext_q, ext_d, extra_q, extra_d;
  logic                inh_q, inh_d, isr_q, isr_d;
  logic [NUM_RUPT-1:0] pend_q, pend_d, take_mask, pend_clr;
  logic [2:0]          eb_q, eb_d;
  logic [4:0]          fb_q, fb_d;
  logic                sb_q, sb_d;
  logic [ADDR_W-1:0]   vec_addr;
  logic                take;

  // Scanning from the top leaves the lowest-numbered pending channel selected.
  always_comb begin
    take_mask = '0;
    vec_addr  = RUPT_BASE;
    for (int i = NUM_RUPT - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        take_mask    = '0;
        take_mask[i] = 1'b1;
        vec_addr     = RUPT_BASE + ADDR_W'(4 * i);
      end
    end
  end

  assign take = (|pend_q) && !inh_q && !ext_q && !isr_q;

  always_comb begin
    state_d  = state_q;
    run_d    = 1'b1;
    z_d      = z_q;
    zrupt_d  = zrupt_q;
    b_d      = b_q;
    brupt_d  = brupt_q;
    ext_d    = ext_q;
    extra_d  = extra_q;
    inh_d    = inh_q;
    isr_d    = isr_q;
    eb_d     = eb_q;
    fb_d     = fb_q;
    sb_d     = sb_q;
    pend_clr = '0;

    case (state_q)
      S_FETCH: begin
        if (run_q && bus.mem_ack) begin
          b_d     = bus.mem_rdata;
          z_d     = z_q + ADDR_W'(1);
          extra_d = ext_q;
          ext_d   = 1'b0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus.exec_done) begin
          if (bus.exec_branch) z_d = bus.exec_target;
          if (bus.exec_extend) ext_d = 1'b1;
          if (bus.exec_inhint) inh_d = 1'b1;
          if (bus.exec_relint) inh_d = 1'b0;
          if (bus.bank_we[0]) eb_d = bus.bank_wdata[2:0];
          if (bus.bank_we[1]) fb_d = bus.bank_wdata;
          if (bus.bank_we[2]) sb_d = bus.bank_wdata[0];
          if (bus.exec_resume) begin
            // Restored B is reissued directly; it carries no extracode context.
            z_d     = zrupt_q;
            b_d     = brupt_q;
            isr_d   = 1'b0;
            extra_d = 1'b0;
            state_d = S_ISSUE;
          end else begin
            state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        state_d = S_FETCH;
        if (take) begin
          zrupt_d  = z_q;
          brupt_d  = b_q;
          z_d      = vec_addr;
          isr_d    = 1'b1;
          pend_clr = take_mask;
        end
      end
      default: state_d = S_FETCH;
    endcase

    pend_d = (pend_q & ~pend_clr) | bus.rupt_req;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      run_q   <= 1'b0;
      z_q     <= RESET_Z;
      zrupt_q <= '0;
      b_q     <= '0;
      brupt_q <= '0;
      ext_q   <= 1'b0;
      extra_q <= 1'b0;
      inh_q   <= 1'b0;
      isr_q   <= 1'b0;
      pend_q  <= '0;
      eb_q    <= '0;
      fb_q    <= '0;
      sb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      z_q     <= z_d;
      zrupt_q <= zrupt_d;
      b_q     <= b_d;
      brupt_q <= brupt_d;
      ext_q   <= ext_d;
      extra_q <= extra_d;
      inh_q   <= inh_d;
      isr_q   <= isr_d;
      pend_q  <= pend_d;
      eb_q    <= eb_d;
      fb_q    <= fb_d;
      sb_q    <= sb_d;
    end
  end

  assign bus.mem_req    = run_q && (state_q == S_FETCH);
  assign bus.mem_addr   = z_q;
  assign bus.mem_ebank  = eb_q;
  assign bus.mem_fbank  = fb_q;
  assign bus.mem_sbank  = sb_q;
  assign bus.ins_valid  = (state_q == S_ISSUE);
  assign bus.ins_opcode = b_q[WORD_W-1 -: 3];
  assign bus.ins_qc     = b_q[WORD_W-4 -: 2];
  assign bus.ins_s      = b_q[ADDR_W:1];
  assign bus.ins_extra  = extra_q;
  assign bus.in_isr     = isr_q;
  assign bus.z_out      = z_q;
  assign bus.zrupt_out  = zrupt_q;
endmodule

// File: tb/tb_agc_sequencer.sv
// Self-checking bench for agc_sequencer: decode table, directed interrupt/extracode/bank/reset sequences,
// then randomized instruction stream against a transaction-level reference model.
module tb_agc_sequencer;
  localparam int         WORD_W    = 16;
  localparam int         ADDR_W    = 12;
  localparam int         NUM_RUPT  = 10;
  localparam logic [11:0] RESET_Z   = 12'o4000;
  localparam logic [11:0] RUPT_BASE = 12'o4004;

  logic clk = 1'b0;
  logic reset;

  agc_sequencer_if #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .NUM_RUPT(NUM_RUPT)) bus ();

  agc_sequencer #(
    .WORD_W(WORD_W), .ADDR_W(ADDR_W), .NUM_RUPT(NUM_RUPT),
    .RESET_Z(RESET_Z), .RUPT_BASE(RUPT_BASE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  // Reference model state (architectural registers only).
  logic [11:0] m_z, m_zr;
  logic [15:0] m_b, m_br;
  logic        m_ext, m_inh, m_isr, m_extra;
  logic [9:0]  m_pend;
  logic [2:0]  m_eb;
  logic [4:0]  m_fb;
  logic        m_sb;

  typedef struct {
    logic [15:0] word;
    int          wt;
    logic [2:0]  op;
    logic [1:0]  qc;
    logic [11:0] s;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_exec();
    bus.exec_done   = 1'b0;
    bus.exec_branch = 1'b0;
    bus.exec_target = '0;
    bus.exec_extend = 1'b0;
    bus.exec_inhint = 1'b0;
    bus.exec_relint = 1'b0;
    bus.exec_resume = 1'b0;
    bus.bank_we     = '0;
    bus.bank_wdata  = '0;
    bus.rupt_req    = '0;
  endtask

  task automatic model_reset();
    m_z = RESET_Z; m_zr = '0; m_b = '0; m_br = '0;
    m_ext = 0; m_inh = 0; m_isr = 0; m_extra = 0;
    m_pend = '0; m_eb = '0; m_fb = '0; m_sb = 0;
  endtask

  task automatic check_issue(input string tag);
    chk({tag, "_valid"}, bus.ins_valid, 1);
    chk({tag, "_op"}, bus.ins_opcode, (m_b >> 13) & 16'h7);
    chk({tag, "_qc"}, bus.ins_qc, (m_b >> 11) & 16'h3);
    chk({tag, "_s"}, bus.ins_s, (m_b >> 1) & 16'h0FFF);
    chk({tag, "_extra"}, bus.ins_extra, m_extra);
    chk({tag, "_z"}, bus.z_out, m_z);
  endtask

  task automatic fetch(input logic [15:0] w, input int wt, input bit stray);
    chk("fetch_req", bus.mem_req, 1);
    chk("fetch_addr", bus.mem_addr, m_z);
    chk("fetch_banks", {bus.mem_ebank, bus.mem_fbank, bus.mem_sbank}, {m_eb, m_fb, m_sb});
    for (int k = 0; k < wt; k++) begin
      if (stray) begin
        bus.exec_done   = 1'b1;
        bus.exec_branch = 1'b1;
        bus.exec_target = 12'($urandom);
        bus.exec_resume = 1'b1;
        bus.exec_inhint = 1'b1;
        bus.exec_extend = 1'b1;
        bus.bank_we     = 3'b111;
        bus.bank_wdata  = 5'($urandom);
      end
      step();
      clear_exec();
      chk("fetch_hold", {bus.mem_req, bus.ins_valid, bus.mem_addr}, {2'b10, m_z});
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = w;
    step();
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 16'($urandom);
    m_b = w; m_z = m_z + 12'd1; m_extra = m_ext; m_ext = 0;
    check_issue("issue");
  endtask

  task automatic exec(input int dly, input bit stray, input logic br, input logic [11:0] tgt,
                      input logic ext, input logic inh, input logic rel, input logic res,
                      input logic [2:0] we, input logic [4:0] wd, input logic [9:0] rq);
    int i;
    for (int k = 0; k < dly; k++) begin
      if (stray) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'($urandom);
      end
      step();
      bus.mem_ack = 1'b0;
      chk("issue_hold", {bus.ins_valid, bus.mem_req, bus.z_out}, {2'b10, m_z});
    end
    bus.exec_done = 1'b1; bus.exec_branch = br; bus.exec_target = tgt;
    bus.exec_extend = ext; bus.exec_inhint = inh; bus.exec_relint = rel; bus.exec_resume = res;
    bus.bank_we = we; bus.bank_wdata = wd; bus.rupt_req = rq;
    step();
    clear_exec();
    m_pend = m_pend | rq;
    if (we[0]) m_eb = wd[2:0];
    if (we[1]) m_fb = wd;
    if (we[2]) m_sb = wd[0];
    if (ext) m_ext = 1;
    if (inh) m_inh = 1;
    if (rel) m_inh = 0;
    if (res) begin
      m_z = m_zr; m_b = m_br; m_isr = 0; m_extra = 0;
      check_issue("resume");
      chk("resume_isr", bus.in_isr, 0);
    end else begin
      if (br) m_z = tgt;
      chk("check_idle", {bus.ins_valid, bus.mem_req}, 2'b00);
      if (m_pend != 0 && !m_inh && !m_ext && !m_isr) begin
        i = 0;
        while (!m_pend[i]) i++;
        m_zr = m_z; m_br = m_b;
        m_z = RUPT_BASE + 12'(4 * i);
        m_pend[i] = 1'b0;
        m_isr = 1;
      end
      step();
      chk("next_req", bus.mem_req, 1);
      chk("next_isr", bus.in_isr, m_isr);
      chk("next_zrupt", bus.zrupt_out, m_zr);
      chk("next_z", bus.z_out, m_z);
    end
  endtask

  task automatic plain();
    exec(0, 0, 0, '0, 0, 0, 0, 0, '0, '0, '0);
  endtask

  task automatic resume_and_finish();
    exec(0, 0, 0, '0, 0, 0, 0, 1, '0, '0, '0);
    plain();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tab[6];
    logic [15:0] w;
    logic [9:0]  rq;
    logic        br, ext, inh, rel, res;
    logic [11:0] tgt;
    logic [2:0]  we;

    tab[0] = '{16'h3005, 0, 3'd1, 2'd2, 12'h802};
    tab[1] = '{16'hFFFF, 2, 3'd7, 2'd3, 12'hFFF};
    tab[2] = '{16'h0000, 0, 3'd0, 2'd0, 12'h000};
    tab[3] = '{16'h8A5A, 1, 3'd4, 2'd1, 12'h52D};
    tab[4] = '{16'h6001, 3, 3'd3, 2'd0, 12'h000};
    tab[5] = '{16'h1801, 0, 3'd0, 2'd3, 12'hC00};

    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    clear_exec();
    reset = 1'b1;
    model_reset();
    repeat (3) step();

    chk("rst_req", bus.mem_req, 0);
    chk("rst_valid", bus.ins_valid, 0);
    chk("rst_z", bus.z_out, 12'o4000);
    chk("rst_zrupt", bus.zrupt_out, 0);
    chk("rst_isr", bus.in_isr, 0);
    chk("rst_banks", {bus.mem_ebank, bus.mem_fbank, bus.mem_sbank}, 0);
    chk("rst_fields", {bus.ins_opcode, bus.ins_qc, bus.ins_s, bus.ins_extra}, 0);

    reset = 1'b0;
    chk("req_before_edge", bus.mem_req, 0);
    step();
    chk("req_first_edge", bus.mem_req, 1);
    chk("first_addr", bus.mem_addr, 12'o4000);

    // Decode table.
    for (int t = 0; t < 6; t++) begin
      fetch(tab[t].word, tab[t].wt, 0);
      chk("tab_op", bus.ins_opcode, tab[t].op);
      chk("tab_qc", bus.ins_qc, tab[t].qc);
      chk("tab_s", bus.ins_s, tab[t].s);
      if (t == 0) chk("tab_z_after_first", bus.z_out, 12'o4001);
      plain();
    end

    // Extracode defers a request raised during its EXTEND.
    fetch(16'h0006, 0, 0);
    exec(0, 0, 0, '0, 1, 0, 0, 0, '0, '0, 10'b00_0000_1000);
    chk("ext_no_entry", bus.in_isr, 0);
    fetch(16'h4321, 0, 0);
    chk("ext_flag_set", bus.ins_extra, 1);
    plain();
    chk("ext_then_entry_addr", bus.mem_addr, 12'o4020);
    chk("ext_then_entry_isr", bus.in_isr, 1);
    fetch(16'h2222, 0, 0);
    chk("ext_flag_clear", bus.ins_extra, 0);
    resume_and_finish();

    // Two requests with Z=04010: channel 1 first, channel 2 after RESUME.
    fetch(16'h1111, 0, 0);
    exec(0, 0, 1, 12'o4010, 0, 0, 0, 0, '0, '0, 10'b00_0000_0110);
    chk("rupt1_addr", bus.mem_addr, 12'o4010);
    chk("rupt1_zrupt", bus.zrupt_out, 12'o4010);
    chk("rupt1_isr", bus.in_isr, 1);
    fetch(16'h5555, 1, 0);
    resume_and_finish();
    chk("rupt2_addr", bus.mem_addr, 12'o4014);
    chk("rupt2_isr", bus.in_isr, 1);
    fetch(16'h7777, 0, 0);
    resume_and_finish();

    // INHINT blocks entry; RELINT releases it at the next CHECK.
    fetch(16'h0004, 0, 0);
    exec(0, 0, 0, '0, 0, 1, 0, 0, '0, '0, 10'b00_0000_0001);
    chk("inh_no_entry", bus.in_isr, 0);
    fetch(16'h0003, 0, 0);
    exec(1, 0, 0, '0, 0, 0, 1, 0, '0, '0, '0);
    chk("relint_entry_addr", bus.mem_addr, 12'o4004);
    chk("relint_entry_isr", bus.in_isr, 1);
    fetch(16'h3000, 0, 0);
    resume_and_finish();

    // Bank write and Z wrap.
    fetch(16'h0005, 0, 0);
    exec(0, 0, 1, 12'hFFF, 0, 0, 0, 0, 3'b010, 5'd17, '0);
    chk("fbank_17", bus.mem_fbank, 17);
    chk("wrap_addr", bus.mem_addr, 12'hFFF);
    fetch(16'h0001, 0, 0);
    chk("wrap_z", bus.z_out, 0);
    plain();

    // Randomized stream.
    for (int n = 0; n < 300; n++) begin
      w = 16'($urandom);
      fetch(w, $urandom_range(0, 2), ($urandom_range(0, 3) == 0));
      do begin
        res = m_isr && ($urandom_range(0, 2) == 0);
        br  = !res && ($urandom_range(0, 4) == 0);
        tgt = ($urandom_range(0, 7) == 0) ? 12'hFFF : 12'($urandom);
        ext = ($urandom_range(0, 7) == 0);
        inh = ($urandom_range(0, 9) == 0);
        rel = ($urandom_range(0, 5) == 0);
        we  = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b000;
        rq  = ($urandom_range(0, 4) == 0) ? (10'(1 << $urandom_range(0, 9)) | 10'(1 << $urandom_range(0, 9))) : 10'd0;
        exec($urandom_range(0, 2), ($urandom_range(0, 2) == 0), br, tgt, ext, inh, rel, res, we, 5'($urandom), rq);
      end while (res);
    end

    // Asynchronous reset while a fetch is outstanding.
    chk("pre_reset_req", bus.mem_req, 1);
    #3;
    reset = 1'b1;
    #1;
    chk("async_rst_req", bus.mem_req, 0);
    chk("async_rst_valid", bus.ins_valid, 0);
    chk("async_rst_z", bus.z_out, 12'o4000);
    chk("async_rst_zrupt", bus.zrupt_out, 0);
    chk("async_rst_isr", bus.in_isr, 0);
    chk("async_rst_banks", {bus.mem_ebank, bus.mem_fbank, bus.mem_sbank}, 0);
    model_reset();
    step();
    reset = 1'b0;
    chk("rerst_req_low", bus.mem_req, 0);
    step();
    fetch(16'h3005, 0, 0);
    plain();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
